// File: rtl/pulse_period_meter_pkg.sv
// Shared types and constants for the pulse period meter and its synchronizer.
package pulse_period_meter_pkg;

  // Measurement state machine.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHigh    = 2'd1,
    StLow     = 2'd2,
    StTimeout = 2'd3
  } state_e;

  localparam int unsigned CntWDefault       = 24;
  localparam int unsigned OvrWDefault       = 16;
  localparam int unsigned SyncStagesDefault = 2;

  // Saturation ceilings for the default widths.
  localparam logic [CntWDefault-1:0] CntMaxDefault = '1;
  localparam logic [OvrWDefault-1:0] OvrMaxDefault = '1;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level, with a history flop that
// yields single-cycle rise and fall strobes in the destination clock domain.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic ps_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ps_o   = sync_q[SYNC_STAGES-1];
  assign rise_o = ps_o & ~hist_q;
  assign fall_o = ~ps_o & hist_q;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures period and high time of the generator pulse train in CLOCK_50
// cycles, flags a stalled input, and counts overflow strobes.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault,
  parameter int unsigned OVR_W       = OvrWDefault
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic             pulse_in,
  input  logic             ovrflow_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic [OVR_W-1:0] ovr_count
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [OVR_W-1:0] OvrMax = '1;
  localparam logic [OVR_W-1:0] OvrOne = OVR_W'(1);

  logic ps;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_i (CLOCK_50),
    .rst_i (KEY0),
    .d_i   (pulse_in),
    .ps_o  (ps),
    .rise_o(rise),
    .fall_o(fall)
  );

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hi_tmp_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             meas_valid_q;
  logic             timeout_q;
  logic             cnt_sat;

  assign cnt_sat = (cnt_q == CntMax);

  // Edges always take priority over saturation so a period of exactly
  // 2^CNT_W-1 cycles still measures instead of timing out.
  always_ff @(posedge CLOCK_50) begin
    if (KEY0) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      hi_tmp_q     <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (!cnt_sat) begin
        cnt_q <= cnt_q + CntOne;
      end
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (rise) begin
            cnt_q   <= CntOne;
            state_q <= StHigh;
          end
        end
        StHigh: begin
          if (rise) begin
            cnt_q <= CntOne;
          end else if (fall) begin
            hi_tmp_q <= cnt_q;
            state_q  <= StLow;
          end else if (cnt_sat) begin
            timeout_q <= 1'b1;
            state_q   <= StTimeout;
          end
        end
        StLow: begin
          if (rise) begin
            period_q     <= cnt_q;
            high_time_q  <= hi_tmp_q;
            meas_valid_q <= 1'b1;
            timeout_q    <= 1'b0;
            cnt_q        <= CntOne;
            state_q      <= StHigh;
          end else if (cnt_sat && !fall) begin
            timeout_q <= 1'b1;
            state_q   <= StTimeout;
          end
        end
        StTimeout: begin
          if (rise) begin
            cnt_q   <= CntOne;
            state_q <= StHigh;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic             ovr_prev_q;
  logic [OVR_W-1:0] ovr_cnt_q;
  logic [OVR_W-1:0] ovr_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (ovrflow_in && !ovr_prev_q && (ovr_cnt_q != OvrMax)) begin
      ovr_cnt_d = ovr_cnt_q + OvrOne;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (KEY0) begin
      ovr_prev_q <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      ovr_prev_q <= ovrflow_in;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign ovr_count  = ovr_cnt_q;

  a_valid_single: assert property (@(posedge CLOCK_50) disable iff (KEY0)
    meas_valid |=> !meas_valid);
  a_cnt_running: assert property (@(posedge CLOCK_50) disable iff (KEY0)
    (state_q != StIdle) |-> (cnt_q != '0));
  a_rise_level: assert property (@(posedge CLOCK_50) disable iff (KEY0)
    rise |-> ps);

endmodule

// File: tb/tb_pulse_period_meter.sv
// Randomized bench for pulse_period_meter: expected results come from the
// pin-level edge times the bench itself drives.
module tb_pulse_period_meter;
  import pulse_period_meter_pkg::*;

  localparam int unsigned CW  = 8;
  localparam int unsigned SS  = 2;
  localparam int unsigned OW  = 16;
  localparam int unsigned OWS = 3;
  localparam int unsigned L   = SS + 1;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pin = 1'b0;
  logic          ovr = 1'b0;
  logic [CW-1:0] per_a, hi_a, per_b, hi_b;
  logic          valid_a, valid_b, to_a, to_b;
  logic [OW-1:0]  ovr_a;
  logic [OWS-1:0] ovr_b;

  pulse_period_meter #(.CNT_W(CW), .SYNC_STAGES(SS), .OVR_W(OW)) dut_a (
    .CLOCK_50(clk), .KEY0(rst), .pulse_in(pin), .ovrflow_in(ovr),
    .period(per_a), .high_time(hi_a), .meas_valid(valid_a), .timeout(to_a),
    .ovr_count(ovr_a)
  );

  pulse_period_meter #(.CNT_W(CW), .SYNC_STAGES(SS), .OVR_W(OWS)) dut_b (
    .CLOCK_50(clk), .KEY0(rst), .pulse_in(pin), .ovrflow_in(ovr),
    .period(per_b), .high_time(hi_b), .meas_valid(valid_b), .timeout(to_b),
    .ovr_count(ovr_b)
  );

  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int unsigned vq_cyc[$];
  int unsigned vq_per[$];
  int unsigned vq_hi[$];
  int unsigned rise_q[$];
  int unsigned fall_q[$];

  always @(negedge clk) begin
    if (!rst && valid_a) begin
      vq_cyc.push_back(cyc);
      vq_per.push_back(int'(per_a));
      vq_hi.push_back(int'(hi_a));
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    vq_cyc.delete(); vq_per.delete(); vq_hi.delete();
    rise_q.delete(); fall_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; pin = 1'b0; ovr = 1'b0;
    tick(5);
    rst = 1'b0;
    clear_logs();
  endtask

  // One pin period: high for h cycles, low for t-h cycles.
  task automatic send(input int unsigned t, input int unsigned h);
    pin = 1'b1; rise_q.push_back(cyc);
    tick(h);
    pin = 1'b0; fall_q.push_back(cyc);
    tick(t - h);
  endtask

  task automatic final_rise();
    pin = 1'b1; rise_q.push_back(cyc);
    tick(L + 3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pin = ~pin; ovr = ~ovr;
      tick(1);
    end
    n_vec++; if (per_a !== '0 || hi_a !== '0) begin
      n_err++; $display("FAIL reset_results: got %0d/%0d want 0/0", per_a, hi_a); end
    n_vec++; if (valid_a !== 1'b0 || to_a !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got valid=%b to=%b want 0/0", valid_a, to_a); end
    n_vec++; if (ovr_a !== '0 || ovr_b !== '0) begin
      n_err++; $display("FAIL reset_ovr: got %0d/%0d want 0/0", ovr_a, ovr_b); end
    n_vec++; if (dut_a.state_q !== StIdle) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", dut_a.state_q, StIdle); end
    pin = 1'b0; ovr = 1'b0;
    tick(1);
    rst = 1'b0;
    clear_logs();
    tick(3);
    final_rise();
    tick(5);
    n_vec++; if (vq_cyc.size() != 0) begin
      n_err++; $display("FAIL first_rise_no_valid: got %0d valids want 0", vq_cyc.size()); end
  endtask

  task automatic test_square_wave();
    do_reset();
    for (int i = 0; i < 6; i++) send(10, 3);
    final_rise();
    n_vec++; if (vq_cyc.size() != rise_q.size() - 1) begin
      n_err++; $display("FAIL square_count: got %0d want %0d", vq_cyc.size(), rise_q.size() - 1); end
    for (int k = 1; k < rise_q.size() && k <= vq_cyc.size(); k++) begin
      n_vec++; if (vq_cyc[k-1] != rise_q[k] + L) begin
        n_err++; $display("FAIL square_latency[%0d]: got %0d want %0d", k, vq_cyc[k-1], rise_q[k] + L); end
      n_vec++; if (vq_per[k-1] != 10 || vq_hi[k-1] != 3) begin
        n_err++; $display("FAIL square_value[%0d]: got %0d/%0d want 10/3", k, vq_per[k-1], vq_hi[k-1]); end
    end
  endtask

  task automatic test_period_change();
    do_reset();
    for (int i = 0; i < 3; i++) send(10, 3);
    for (int i = 0; i < 3; i++) send(25, 12);
    final_rise();
    n_vec++; if (vq_cyc.size() != 6) begin
      n_err++; $display("FAIL change_count: got %0d want 6", vq_cyc.size()); end
    for (int k = 1; k <= 6 && k <= vq_cyc.size(); k++) begin
      n_vec++;
      if (vq_per[k-1] != (k <= 3 ? 10 : 25) || vq_hi[k-1] != (k <= 3 ? 3 : 12)) begin
        n_err++; $display("FAIL change_value[%0d]: got %0d/%0d want %0d/%0d", k, vq_per[k-1],
                          vq_hi[k-1], (k <= 3 ? 10 : 25), (k <= 3 ? 3 : 12));
      end
    end
  endtask

  // Random periods plus two of exactly 2^CNT_W-1 where edge and saturation coincide.
  task automatic test_random();
    int unsigned t, h;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      t = $urandom_range(120, 2);
      h = $urandom_range(t - 1, 1);
      send(t, h);
    end
    send(SAT, 100);
    send(SAT, SAT - 1);
    final_rise();
    n_vec++; if (vq_cyc.size() != rise_q.size() - 1) begin
      n_err++; $display("FAIL random_count: got %0d want %0d", vq_cyc.size(), rise_q.size() - 1); end
    for (int k = 1; k < rise_q.size() && k <= vq_cyc.size(); k++) begin
      n_vec++; if (vq_cyc[k-1] != rise_q[k] + L) begin
        n_err++; $display("FAIL random_latency[%0d]: got %0d want %0d", k, vq_cyc[k-1], rise_q[k] + L); end
      n_vec++; if (vq_per[k-1] != rise_q[k] - rise_q[k-1]) begin
        n_err++; $display("FAIL random_period[%0d]: got %0d want %0d", k, vq_per[k-1],
                          rise_q[k] - rise_q[k-1]); end
      n_vec++; if (vq_hi[k-1] != fall_q[k-1] - rise_q[k-1]) begin
        n_err++; $display("FAIL random_high[%0d]: got %0d want %0d", k, vq_hi[k-1],
                          fall_q[k-1] - rise_q[k-1]); end
    end
    n_vec++; if (to_a !== 1'b0) begin
      n_err++; $display("FAIL random_no_timeout: got %b want 0", to_a); end
  endtask

  task automatic test_timeout();
    int unsigned r, r2;
    do_reset();
    send(10, 3);
    send(10, 3);
    r = cyc;
    pin = 1'b1; tick(4); pin = 1'b0;
    tick(r + L + SAT - 1 - cyc);
    n_vec++; if (to_a !== 1'b0) begin
      n_err++; $display("FAIL timeout_early: got %b want 0 at cycle %0d", to_a, cyc); end
    tick(1);
    n_vec++; if (to_a !== 1'b1) begin
      n_err++; $display("FAIL timeout_set: got %b want 1 at cycle %0d", to_a, cyc); end
    n_vec++; if (per_a !== 10 || hi_a !== 3) begin
      n_err++; $display("FAIL timeout_hold: got %0d/%0d want 10/3", per_a, hi_a); end
    n_vec++; if (dut_a.state_q !== StTimeout) begin
      n_err++; $display("FAIL timeout_state: got %0d want %0d", dut_a.state_q, StTimeout); end
    tick(20);
    vq_cyc.delete(); vq_per.delete(); vq_hi.delete();
    send(20, 5);
    r2 = cyc;
    pin = 1'b1;
    tick(L - 1);
    n_vec++; if (to_a !== 1'b1 || vq_cyc.size() != 0) begin
      n_err++; $display("FAIL timeout_first_rise: got to=%b valids=%0d want 1/0", to_a, vq_cyc.size()); end
    tick(1);
    n_vec++; if (valid_a !== 1'b1 || to_a !== 1'b0 || cyc != r2 + L) begin
      n_err++; $display("FAIL timeout_recover: got valid=%b to=%b want 1/0", valid_a, to_a); end
    n_vec++; if (per_a !== 20 || hi_a !== 5) begin
      n_err++; $display("FAIL timeout_value: got %0d/%0d want 20/5", per_a, hi_a); end
  endtask

  task automatic test_overflow();
    int unsigned pulses = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ovr = 1'b1; tick(i == 5 ? 4 : 1);
      ovr = 1'b0; tick($urandom_range(4, 1));
      pulses++;
    end
    tick(2);
    n_vec++; if (ovr_a !== OW'(pulses)) begin
      n_err++; $display("FAIL ovr_count6: got %0d want %0d", ovr_a, pulses); end
    n_vec++; if (ovr_b !== OWS'(pulses)) begin
      n_err++; $display("FAIL ovr_small6: got %0d want %0d", ovr_b, pulses); end
    for (int i = 0; i < 4; i++) begin
      ovr = 1'b1; tick($urandom_range(3, 1));
      ovr = 1'b0; tick($urandom_range(3, 1));
      pulses++;
    end
    tick(2);
    n_vec++; if (ovr_a !== OW'(pulses)) begin
      n_err++; $display("FAIL ovr_count10: got %0d want %0d", ovr_a, pulses); end
    n_vec++; if (ovr_b !== OWS'((1 << OWS) - 1)) begin
      n_err++; $display("FAIL ovr_saturate: got %0d want %0d", ovr_b, (1 << OWS) - 1); end
  endtask

  task automatic test_reset_mid();
    int unsigned r;
    do_reset();
    send(10, 3);
    send(10, 3);
    pin = 1'b1; tick(4); pin = 1'b0; tick(5);
    n_vec++; if (dut_a.state_q !== StLow || per_a !== 10) begin
      n_err++; $display("FAIL mid_precondition: got state=%0d per=%0d want %0d/10",
                        dut_a.state_q, per_a, StLow); end
    rst = 1'b1; tick(1);
    n_vec++; if (per_a !== '0 || hi_a !== '0 || valid_a !== 1'b0 || to_a !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %0d/%0d/%b/%b want 0/0/0/0",
                        per_a, hi_a, valid_a, to_a); end
    rst = 1'b0;
    clear_logs();
    send(15, 6);
    n_vec++; if (vq_cyc.size() != 0) begin
      n_err++; $display("FAIL mid_one_rise: got %0d valids want 0", vq_cyc.size()); end
    r = cyc;
    final_rise();
    n_vec++; if (vq_cyc.size() != 1) begin
      n_err++; $display("FAIL mid_two_rises: got %0d valids want 1", vq_cyc.size());
    end else begin
      n_vec++; if (vq_per[0] != 15 || vq_hi[0] != 6 || vq_cyc[0] != r + L) begin
        n_err++; $display("FAIL mid_value: got %0d/%0d@%0d want 15/6@%0d",
                          vq_per[0], vq_hi[0], vq_cyc[0], r + L); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(2);
    test_reset();
    test_square_wave();
    test_period_change();
    test_random();
    test_timeout();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
- Receive-side counterpart of the counter/pulse generator block.
- Consumes the generator's pin output pulse train and its overflow strobe.
- Measures period and high time in CLOCK_50 cycles and counts overflow events.
- Sits beside the generator in the top-level and feeds the self-checking bench and on-board indicators.

Parameters:
- CNT_W, 24, width of the period/high-time counters and result registers.
- SYNC_STAGES, 2, number of synchronizer flops on pulse_in (minimum 2).
- OVR_W, 16, width of the overflow event counter.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- KEY0  in  1  reset; synchronous, active-high.
- pulse_in  in  1  pulse train from the generator; treated as asynchronous.
- ovrflow_in  in  1  generator overflow flag; synchronous to CLOCK_50.
- period  out  CNT_W  last measured rise-to-rise distance, in cycles.
- high_time  out  CNT_W  last measured rise-to-fall distance, in cycles.
- meas_valid  out  1  one-cycle strobe when period and high_time update.
- timeout  out  1  sticky flag: counter saturated with no edge.
- ovr_count  out  OVR_W  count of ovrflow_in rising edges, saturating.

Behaviour:
- Reset (KEY0=1 at a clock edge): period=0, high_time=0, meas_valid=0, timeout=0, ovr_count=0, cnt=0, state=IDLE, synchronizer and edge flops cleared. Reset mid-measurement discards any partial result.
- Input conditioning: pulse_in passes through SYNC_STAGES flops to give ps, plus one history flop.
  - rise = ps & ~ps_d; fall = ~ps & ps_d.
  - Latency from a pin edge to rise/fall is SYNC_STAGES+1 cycles.
- Counter cnt:
  - Loads 1 in the cycle after a rise, then increments by 1 each cycle.
  - Saturates at 2^CNT_W-1; never wraps.
- States:
  - IDLE: wait for the first rise. On rise -> HIGH, load cnt. No measurement is produced from IDLE.
  - HIGH:
    - On fall: hi_tmp <= cnt, -> LOW.
    - On rise before any fall (glitch or missed fall): restart cnt, stay in HIGH, no valid.
  - LOW: on rise, the following all happen in the same cycle:
    - period <= cnt, high_time <= hi_tmp;
    - meas_valid=1 for exactly that cycle; timeout <= 0;
    - reload cnt; -> HIGH.
  - TIMEOUT: entered from HIGH or LOW when cnt reaches saturation and no edge occurs that cycle.
    - timeout <= 1; period and high_time hold their old values.
    - On rise -> HIGH, load cnt. No valid is produced for this first edge.
- Edge and saturation in the same cycle: the edge wins and saturation is ignored.
- Result definition: for an input with period T cycles and high H cycles, period=T and high_time=H.
- ovr_count:
  - Increments on each ovrflow_in 0->1 transition (internal history flop).
  - Holds at 2^OVR_W-1.
  - Independent of the state machine; active in every state except reset.
- meas_valid is a single-cycle pulse and is never asserted two cycles in a row.

Decomposition:
- Shared package holds:
  - State enum (IDLE, HIGH, LOW, TIMEOUT), 2-bit encoding.
  - CNT_W and OVR_W default constants.
  - Saturation-max helper constants.
- One sub-module: sync_edge_detect (SYNC_STAGES parameter; outputs ps, rise, fall), reusable for the KEY inputs elsewhere.
- Counters and FSM stay in the top module.

Test Plan:
- Reset check: hold KEY0=1 for 5 cycles with pulse_in toggling -> all outputs 0 and state IDLE; release -> first rise produces no meas_valid.
- Steady square wave, period 10, high 3 -> from the second rise onward, meas_valid pulses every 10 cycles with period=10, high_time=3, and latency SYNC_STAGES+1 from the pin edge.
- Duty and period change: switch to period 25, high 12 -> the first valid after the switch reports 25/12, with no intermediate garbage value.
- Timeout: CNT_W=8 override, pulse_in held low after one rise -> timeout=1 once cnt reaches 255, period held; next rise clears nothing; the rise after that gives a valid and timeout=0.
- Overflow counting: 5 one-cycle ovrflow_in pulses plus one 4-cycle-wide pulse -> ovr_count=6. With OVR_W=3 and 10 pulses -> ovr_count=7.
- Reset mid-measurement: assert KEY0 while in LOW -> outputs return to 0 and the next measurement requires two rises.
